vic_reg_master: RTL and testbench

Host-side initiator for the VIC register file port. Accepts write/read commands over a valid/ready stream, buffers them in a small command FIFO, and sequences each into the register file's address/data/write-enable/read-enable strobes. Read results come back on a valid/ready response stream. Sits between the host/CPU bus adapter and the VIC register file, which it drives directly.

---
 rtl/vic_reg_master.sv | 150 +++++++++++++++
 tb/tb_vic_reg_master.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vic_reg_master.sv
// VIC register file initiator: command FIFO feeding a strobe sequencer,
// with read results returned on a valid/ready response stream.
module vic_reg_master #(
  parameter int ADDR_W     = 5,
  parameter int DATA_W     = 4,
  parameter int RD_LAT     = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_cmd_valid,
  output logic              o_cmd_ready,
  input  logic              i_cmd_wr,
  input  logic [ADDR_W-1:0] i_cmd_addr,
  input  logic [DATA_W-1:0] i_cmd_data,
  output logic              o_rsp_valid,
  input  logic              i_rsp_ready,
  output logic [ADDR_W-1:0] o_rsp_addr,
  output logic [DATA_W-1:0] o_rsp_data,
  output logic [ADDR_W-1:0] o_VIC_regaddr,
  output logic [DATA_W-1:0] o_VIC_data,
  output logic              o_VIC_we,
  output logic              o_VIC_re,
  input  logic [DATA_W-1:0] i_VIC_data,
  output logic              o_busy
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = 3;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SETUP  = 3'd1;
  localparam logic [2:0] S_STROBE = 3'd2;
  localparam logic [2:0] S_HOLD   = 3'd3;
  localparam logic [2:0] S_READ   = 3'd4;
  localparam logic [2:0] S_RESP   = 3'd5;

  typedef struct packed {
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } cmd_t;

  cmd_t          mem [FIFO_DEPTH];
  cmd_t          head;
  logic [PW:0]   wp;
  logic [PW:0]   rp;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic [2:0]    state;
  logic [CW-1:0] cnt;
  logic          op_wr;

  // Extra pointer bit separates full from empty when indices match.
  assign empty = (wp == rp);
  assign full  = (wp[PW] != rp[PW]) &&
                 (wp[PW-1:0] == rp[PW-1:0]);

  assign o_cmd_ready = ~full;
  assign push        = i_cmd_valid & ~full;
  assign head        = mem[rp[PW-1:0]];

  assign o_VIC_we = (state == S_STROBE);
  assign o_VIC_re = (state == S_READ);
  assign o_busy   = ~empty | (state != S_IDLE);

  always_comb begin
    pop = 1'b0;
    unique case (state)
      S_IDLE:  pop = ~empty;
      S_HOLD:  pop = ~empty;
      S_RESP:  pop = i_rsp_ready & ~empty;
      default: pop = 1'b0;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (push) begin
      mem[wp[PW-1:0]] <= '{
        wr:   i_cmd_wr,
        addr: i_cmd_addr,
        data: i_cmd_data
      };
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop)  rp <= rp + 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state         <= S_IDLE;
      cnt           <= '0;
      op_wr         <= 1'b0;
      o_VIC_regaddr <= '0;
      o_VIC_data    <= '0;
      o_rsp_valid   <= 1'b0;
      o_rsp_addr    <= '0;
      o_rsp_data    <= '0;
    end else begin
      if (pop) begin
        o_VIC_regaddr <= head.addr;
        o_VIC_data    <= head.data;
        op_wr         <= head.wr;
      end
      unique case (state)
        S_IDLE: begin
          if (!empty) state <= S_SETUP;
        end
        S_SETUP: begin
          cnt   <= '0;
          state <= op_wr ? S_STROBE : S_READ;
        end
        S_STROBE: begin
          state <= S_HOLD;
        end
        S_HOLD: begin
          state <= empty ? S_IDLE : S_SETUP;
        end
        S_READ: begin
          if (cnt == CW'(RD_LAT - 1)) begin
            o_rsp_data  <= i_VIC_data;
            o_rsp_addr  <= o_VIC_regaddr;
            o_rsp_valid <= 1'b1;
            state       <= S_RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_RESP: begin
          if (i_rsp_ready) begin
            o_rsp_valid <= 1'b0;
            state       <= empty ? S_IDLE : S_SETUP;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vic_reg_master.sv
// Randomized self-checking bench for vic_reg_master with a
// transaction-level command/response model and register file.
module tb_vic_reg_master;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       cmd_valid, cmd_wr, rsp_ready;
  logic [4:0] cmd_addr;
  logic [3:0] cmd_data;
  logic       cmd_ready, rsp_valid, we, re, busy;
  logic [4:0] rsp_addr, regaddr;
  logic [3:0] rsp_data, vdata, vic_rd;

  logic       c3_valid, c3_wr, c3_rdy;
  logic [4:0] c3_addr;
  logic [3:0] c3_data;
  logic       c3_cready, c3_rvalid, we3, re3, busy3;
  logic [4:0] c3_raddr, regaddr3;
  logic [3:0] c3_rdata, vdata3, vic_rd3;
  logic [3:0] re_seen3;

  vic_reg_master #(
    .ADDR_W(5), .DATA_W(4), .RD_LAT(1), .FIFO_DEPTH(4)
  ) dut (
    .i_clk(clk), .i_rst(rst_n),
    .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready),
    .i_cmd_wr(cmd_wr), .i_cmd_addr(cmd_addr),
    .i_cmd_data(cmd_data),
    .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready),
    .o_rsp_addr(rsp_addr), .o_rsp_data(rsp_data),
    .o_VIC_regaddr(regaddr), .o_VIC_data(vdata),
    .o_VIC_we(we), .o_VIC_re(re),
    .i_VIC_data(vic_rd), .o_busy(busy)
  );

  vic_reg_master #(
    .ADDR_W(5), .DATA_W(4), .RD_LAT(3), .FIFO_DEPTH(4)
  ) dut3 (
    .i_clk(clk), .i_rst(rst_n),
    .i_cmd_valid(c3_valid), .o_cmd_ready(c3_cready),
    .i_cmd_wr(c3_wr), .i_cmd_addr(c3_addr),
    .i_cmd_data(c3_data),
    .o_rsp_valid(c3_rvalid), .i_rsp_ready(c3_rdy),
    .o_rsp_addr(c3_raddr), .o_rsp_data(c3_rdata),
    .o_VIC_regaddr(regaddr3), .o_VIC_data(vdata3),
    .o_VIC_we(we3), .o_VIC_re(re3),
    .i_VIC_data(vic_rd3), .o_busy(busy3)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input int act,
                       input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h",
               name, act, exp);
    end
  endtask

  // register file attached to the RD_LAT=1 instance
  logic [3:0] rf [32];
  always @(posedge clk) if (we) rf[regaddr] <= vdata;
  assign vic_rd = rf[regaddr];

  // RD_LAT=3 file returns a value that changes every READ cycle
  always @(posedge clk) re_seen3 <= re3 ? re_seen3 + 4'd1 : 4'd0;
  assign vic_rd3 = 4'hA + re_seen3;

  // ready driver: 0 = hold low, 1 = hold high, 2 = random
  int rdy_mode = 1;
  always @(posedge clk) begin
    #1;
    if (rdy_mode == 2) rsp_ready = 1'($urandom_range(0, 1));
    else               rsp_ready = (rdy_mode == 1);
  end

  typedef struct { bit wr; bit [4:0] a; bit [3:0] d; } cmd_s;
  typedef struct { bit [4:0] a; bit [3:0] d; } rsp_s;

  cmd_s       exp_q[$];
  rsp_s       rsp_q[$];
  rsp_s       rsp_log[$];
  logic [3:0] mregs [32];
  cmd_s       cur;
  rsp_s       er;
  bit         prev_we, prev_re, prev_valid, prev_acc;
  int         re_run;
  logic [4:0] prev_raddr;
  logic [3:0] prev_rdata;
  logic [3:0] last_rsp_data;

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      rsp_q.delete();
      prev_we = 0; prev_re = 0;
      prev_valid = 0; prev_acc = 0;
      re_run = 0;
    end else begin
      check("we_re_exclusive", int'(we & re), 0);
      if (exp_q.size() != 0 || rsp_q.size() != 0)
        check("busy_pending", int'(busy), 1);
      if (we) begin
        check("we_one_cycle", int'(prev_we), 0);
        if (exp_q.size() == 0) begin
          check("unexpected_we", 1, 0);
        end else begin
          cur = exp_q.pop_front();
          check("we_cmd_is_write", int'(cur.wr), 1);
          check("we_addr", int'(regaddr), int'(cur.a));
          check("we_data", int'(vdata), int'(cur.d));
          mregs[cur.a] = cur.d;
        end
      end
      if (re) re_run++;
      if (re && !prev_re) begin
        if (exp_q.size() == 0) begin
          check("unexpected_re", 1, 0);
        end else begin
          cur = exp_q.pop_front();
          check("re_cmd_is_read", int'(cur.wr), 0);
          check("re_addr", int'(regaddr), int'(cur.a));
          rsp_q.push_back('{a: cur.a, d: mregs[cur.a]});
        end
      end
      if (!re && prev_re) begin
        check("re_length", re_run, 1);
        re_run = 0;
      end
      if (rsp_valid && prev_valid && !prev_acc) begin
        check("rsp_addr_stable", int'(rsp_addr), int'(prev_raddr));
        check("rsp_data_stable", int'(rsp_data), int'(prev_rdata));
      end
      if (rsp_valid && rsp_ready) begin
        if (rsp_q.size() == 0) begin
          check("unexpected_rsp", 1, 0);
        end else begin
          er = rsp_q.pop_front();
          check("rsp_addr", int'(rsp_addr), int'(er.a));
          check("rsp_data", int'(rsp_data), int'(er.d));
        end
        rsp_log.push_back('{a: rsp_addr, d: rsp_data});
        last_rsp_data = rsp_data;
      end
      if (cmd_valid && cmd_ready)
        exp_q.push_back('{wr: cmd_wr, a: cmd_addr, d: cmd_data});
      prev_we    = we;
      prev_re    = re;
      prev_valid = rsp_valid;
      prev_acc   = rsp_valid & rsp_ready;
      prev_raddr = rsp_addr;
      prev_rdata = rsp_data;
    end
  end

  task automatic push(input bit wr, input bit [4:0] a,
                      input bit [3:0] d);
    int n = 0;
    cmd_valid = 1'b1;
    cmd_wr    = wr;
    cmd_addr  = a;
    cmd_data  = d;
    forever begin
      @(negedge clk);
      if (cmd_ready) break;
      n++;
      if (n > 500) begin
        check("push_timeout", 1, 0);
        break;
      end
    end
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    forever begin
      @(negedge clk);
      if (!busy && exp_q.size() == 0 && rsp_q.size() == 0) break;
      n++;
      if (n > 3000) begin
        check("drain_timeout", 1, 0);
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  logic [3:0] wd [32];
  bit   [4:0] ws [6];
  bit   [3:0] ds [6];
  int   cnt, first_k, got3;
  logic saw_v3;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    cmd_valid = 0; cmd_wr = 0; cmd_addr = 0; cmd_data = 0;
    c3_valid = 0; c3_wr = 0; c3_addr = 0; c3_data = 0;
    c3_rdy = 1;
    rdy_mode = 1;
    rsp_ready = 1;
    for (int i = 0; i < 32; i++) begin
      rf[i] = 0;
      mregs[i] = 0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cmd_ready", int'(cmd_ready), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_rsp_valid", int'(rsp_valid), 0);
    check("rst_we", int'(we | re), 0);
    check("rst_regaddr", int'(regaddr), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // single write: latency and stable address/data
    @(posedge clk); #1;
    cmd_valid = 1; cmd_wr = 1; cmd_addr = 5'h0A; cmd_data = 4'h7;
    @(posedge clk); #1;
    cmd_valid = 0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k == 1) check("sw_busy_after_push", int'(busy), 1);
      check($sformatf("sw_we_k%0d", k), int'(we), int'(k == 3));
      if (k >= 2 && k <= 4) begin
        check("sw_regaddr", int'(regaddr), 5'h0A);
        check("sw_data", int'(vdata), 4'h7);
      end
    end
    wait_idle();

    // reset mid-STROBE with a second write waiting
    push(1, 5'h03, 4'h5);
    push(1, 5'h04, 4'h6);
    cnt = 0;
    while (!we && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    check("rst_reached_strobe", int'(we), 1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_we", int'(we), 0);
    check("rst_async_busy", int'(busy), 0);
    check("rst_async_rsp_valid", int'(rsp_valid), 0);
    check("rst_async_cmd_ready", int'(cmd_ready), 1);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    cnt = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (we || re) cnt++;
    end
    check("rst_no_stale_cmd", cnt, 0);
    check("rst_idle_busy", int'(busy), 0);
    @(posedge clk); #1;

    // write all addresses, then read them back in order
    for (int a = 0; a < 32; a++) wd[a] = 4'($urandom_range(0, 15));
    rsp_log.delete();
    for (int a = 0; a < 32; a++) push(1, 5'(a), wd[a]);
    for (int a = 0; a < 32; a++) push(0, 5'(a), 4'h0);
    wait_idle();
    check("sweep_rsp_count", rsp_log.size(), 32);
    for (int i = 0; i < rsp_log.size() && i < 32; i++) begin
      check("sweep_addr", int'(rsp_log[i].a), i);
      check("sweep_data", int'(rsp_log[i].d), int'(wd[i]));
    end

    // backpressure: read stalls in RESP while FIFO fills
    rdy_mode = 0;
    repeat (2) @(posedge clk);
    #1;
    rsp_log.delete();
    ws = '{5'h03, 5'h03, 5'h07, 5'h08, 5'h09, 5'h03};
    ds = '{4'h0, ~wd[3], 4'h1, 4'h2, 4'h3, 4'h0};
    push(0, ws[0], ds[0]);
    for (int i = 1; i < 5; i++) push(1, ws[i], ds[i]);
    check("bp_full_ready", int'(cmd_ready), 0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("bp_stall_ready", int'(cmd_ready), 0);
      check("bp_stall_valid", int'(rsp_valid), 1);
      check("bp_stall_data", int'(rsp_data), int'(wd[3]));
    end
    @(posedge clk); #1;
    rdy_mode = 1;
    push(0, ws[5], ds[5]);
    wait_idle();
    check("bp_rsp_count", rsp_log.size(), 2);
    if (rsp_log.size() == 2) begin
      check("bp_first", int'(rsp_log[0].d), int'(wd[3]));
      check("bp_second", int'(rsp_log[1].d), int'(ds[1]));
    end

    // write immediately followed by read of the same register
    push(1, 5'h1F, 4'hC);
    push(0, 5'h1F, 4'h0);
    wait_idle();
    check("order_wr_then_rd", int'(last_rsp_data), 4'hC);

    // random traffic with random response backpressure
    rdy_mode = 2;
    for (int i = 0; i < 80; i++) begin
      push(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
           4'($urandom_range(0, 15)));
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    wait_idle();
    rdy_mode = 1;

    // RD_LAT=3 instance: sample at end of third READ cycle
    @(posedge clk); #1;
    c3_valid = 1; c3_wr = 0; c3_addr = 5'h11;
    @(posedge clk); #1;
    c3_valid = 0;
    cnt = 0; first_k = 0; got3 = -1; saw_v3 = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (re3) begin
        cnt++;
        if (first_k == 0) first_k = k;
      end
      check("lat3_excl", int'(we3 & re3), 0);
      if (c3_rvalid && !saw_v3) begin
        saw_v3 = 1;
        got3 = k;
        check("lat3_rsp_data", int'(c3_rdata), 4'hC);
        check("lat3_rsp_addr", int'(c3_raddr), 5'h11);
      end
    end
    check("lat3_re_cycles", cnt, 3);
    check("lat3_re_start", first_k, 3);
    check("lat3_rsp_cycle", got3, 6);
    check("lat3_idle", int'(busy3), 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
